lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store initiator between the EX stage and the 64-bit physical memory port. The memory port exposes ce/we/addr/wdata/wmask plus a read-data return.
- Accepts one load or store per handshake and drives a doubleword-aligned request with a byte mask.
- Waits for the memory response. For loads, extracts, shifts and sign/zero-extends the addressed bytes.
- Returns one completion to write-back. Single outstanding transaction; misaligned accesses fault without touching memory.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, memory data width (fixed 64; byte lanes = 8)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  EX has a load/store
- req_ready  out  1  block can accept (high only in IDLE)
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte 1=half 2=word 3=double
- req_unsigned  in  1  load zero-extend when 1
- req_addr  in  64  byte address
- req_wdata  in  64  store data, LSB-justified
- mem_ce  out  1  memory request valid
- mem_we  out  1  memory write enable
- mem_addr  out  64  doubleword-aligned address (addr[2:0]=0)
- mem_wdata  out  64  lane-shifted store data
- mem_wmask  out  8  byte-lane mask
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  response valid (loads and stores)
- mem_rdata  in  64  read doubleword
- resp_valid  out  1  completion to WB
- resp_ready  in  1  WB accepts completion
- resp_rdata  out  64  extended load data; 0 for stores/faults
- resp_err  out  1  misaligned fault

Behaviour:
- Clock is clk; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset: state=IDLE; all outputs 0 except req_ready=1. Reset asserted mid-transaction abandons it and issues no completion; a later late mem_rvalid is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch we/size/unsigned/addr/wdata.
  - If aligned (addr mod 2^size == 0) go to REQ.
  - Otherwise go directly to RESP with resp_err=1, rdata=0.
- REQ: mem_ce=1; mem_addr, mem_we, mem_wdata, mem_wmask stable from latched values.
  - mem_ready=1 → WAIT. If mem_rvalid is also 1 in the same cycle, capture rdata and go straight to RESP.
  - Held indefinitely while mem_ready=0.
- WAIT: mem_ce=0. On mem_rvalid, capture mem_rdata → RESP.
- RESP: resp_valid=1, outputs stable until resp_ready; then → IDLE. No new request is accepted in the cycle of completion (req_ready rises the next cycle).
- Minimum latency: req accept → resp_valid = 2 cycles with mem_ready=mem_rvalid=1 in REQ.
- Byte offset and mask: off=addr[2:0].
  - base mask = 0x01/0x03/0x0F/0xFF for size 0/1/2/3.
  - mem_wmask = base<<off for stores; for loads the same mask (informational), mem_we=0.
- Store data: mem_wdata = req_wdata << (8*off); bits outside the mask are don't-care but must be driven deterministically as the shifted value.
- Load data: raw = mem_rdata >> (8*off); keep the low 8·2^size bits, then sign-extend from the top bit unless req_unsigned. req_unsigned is ignored for size=3.
- Store completion: resp_rdata=0, resp_err=0.
- Misaligned fault: no mem_ce pulse at all; resp_valid the cycle after accept.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - state enum IDLE/REQ/WAIT/RESP;
  - the function computing the base mask from size.
- One sub-module, lsu_load_align: purely combinational (rdata, off, size, unsigned) → extended 64-bit value. It is unit-testable on its own.

Test Plan:
- Load byte signed: addr=0x80000005, mem_rdata=0x0000_8000_0000_0000 → mem_addr=0x80000000, wmask=0x20, resp_rdata=0xFFFF_FFFF_FFFF_FF80.
- Store half: addr=0x80000006, wdata=0x1234 → mem_we=1, wmask=0xC0, mem_wdata[63:48]=0x1234; resp_rdata=0, err=0.
- Load word unsigned: addr=0x80000004, mem_rdata=0x8765_4321_0000_0000 → resp_rdata=0x0000_0000_8765_4321.
- Misaligned word: addr=0x80000002, size=2 → mem_ce never asserted, resp_valid one cycle after accept, resp_err=1.
- Backpressure: mem_ready low 3 cycles, then mem_rvalid 2 cycles later; resp_ready low 2 cycles → mem_ce held 4 cycles with stable addr/mask; resp_valid held 3 cycles with stable data; req_ready=0 throughout.
- Reset during WAIT, then stray mem_rvalid in IDLE → no resp_valid; next load completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Purpose : shared types, widths and byte-mask helpers for the LSU memory master.
// Latency : n/a (types and pure functions only).
// Backpres: n/a.
package lsu_pkg;

  localparam int LSU_ADDR_W = 64;
  localparam int LSU_DATA_W = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // Byte-lane mask of an access of the given size, starting at lane 0.
  function automatic logic [7:0] base_mask(size_t sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Natural alignment: the offset's low size bits must all be zero.
  function automatic logic is_aligned(logic [2:0] off, size_t sz);
    case (sz)
      SZ_B:    return 1'b1;
      SZ_H:    return off[0] == 1'b0;
      SZ_W:    return off[1:0] == 2'b00;
      default: return off == 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Purpose : bundles the EX request, memory port and WB completion signals.
// Ports   : master = LSU view (drives req_ready, mem_*, resp_*); slave = EX/memory/WB view.
// Backpres: req_valid/req_ready, mem_ce/mem_ready, resp_valid/resp_ready handshakes.
interface lsu_mem_master_if;
  import lsu_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [LSU_ADDR_W-1:0] req_addr;
  logic [LSU_DATA_W-1:0] req_wdata;

  logic                  mem_ce;
  logic                  mem_we;
  logic [LSU_ADDR_W-1:0] mem_addr;
  logic [LSU_DATA_W-1:0] mem_wdata;
  logic [7:0]            mem_wmask;
  logic                  mem_ready;
  logic                  mem_rvalid;
  logic [LSU_DATA_W-1:0] mem_rdata;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [LSU_DATA_W-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_ready, mem_rvalid, mem_rdata, resp_ready,
    output req_ready, mem_ce, mem_we, mem_addr, mem_wdata, mem_wmask,
    output resp_valid, resp_rdata, resp_err
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_ready, mem_rvalid, mem_rdata, resp_ready,
    input  req_ready, mem_ce, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/lsu_load_align.sv
// Purpose : shift the addressed bytes of a read doubleword down and sign/zero-extend them.
// Ports   : i_rdata/i_off/i_size/i_unsigned in, o_data out. Latency 0 (combinational).
// Backpres: none.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] i_rdata,
  input  logic [2:0]  i_off,
  input  size_t       i_size,
  input  logic        i_unsigned,
  output logic [63:0] o_data
);

  logic [63:0] w_raw;

  assign w_raw = i_rdata >> {i_off, 3'b000};

  // Doubleword loads have nothing to extend, so i_unsigned is irrelevant there.
  always_comb begin
    o_data = w_raw;
    case (i_size)
      SZ_B:    o_data = {{56{~i_unsigned & w_raw[7]}},  w_raw[7:0]};
      SZ_H:    o_data = {{48{~i_unsigned & w_raw[15]}}, w_raw[15:0]};
      SZ_W:    o_data = {{32{~i_unsigned & w_raw[31]}}, w_raw[31:0]};
      default: o_data = w_raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Purpose : single-outstanding load/store initiator from EX to the 64-bit memory port.
// Ports   : clk, reset (sync, active-high), bus (master modport). Latency: accept->resp_valid 2 cycles min, 1 for faults.
// Backpres: mem_ce held until mem_ready; resp held until resp_ready; req_ready only in IDLE.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  lsu_mem_master_if.master   bus
);

  state_t              r_state;
  logic                r_we;
  size_t               r_size;
  logic                r_unsigned;
  logic [2:0]          r_off;

  logic                r_req_ready;
  logic                r_mem_ce;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [7:0]          r_mem_wmask;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_resp_err;

  size_t               w_size;
  logic [2:0]          w_off;
  logic [63:0]         w_load_data;
  logic [DATA_W-1:0]   w_capture;

  assign w_size = size_t'(bus.req_size);
  assign w_off  = bus.req_addr[2:0];

  lsu_load_align u_load_align (
    .i_rdata    (bus.mem_rdata),
    .i_off      (r_off),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_load_data)
  );

  // Stores complete with zero data; loads return the aligned, extended value.
  assign w_capture = r_we ? '0 : w_load_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_size       <= SZ_B;
      r_unsigned   <= 1'b0;
      r_off        <= 3'd0;
      r_req_ready  <= 1'b1;
      r_mem_ce     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wmask  <= 8'h00;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we        <= bus.req_we;
            r_size      <= w_size;
            r_unsigned  <= bus.req_unsigned;
            r_off       <= w_off;
            r_req_ready <= 1'b0;
            if (is_aligned(w_off, w_size)) begin
              r_state     <= REQ;
              r_mem_ce    <= 1'b1;
              r_mem_we    <= bus.req_we;
              r_mem_addr  <= {bus.req_addr[ADDR_W-1:3], 3'b000};
              r_mem_wdata <= bus.req_wdata << {w_off, 3'b000};
              r_mem_wmask <= base_mask(w_size) << w_off;
            end else begin
              // Misaligned: fault straight away, memory is never touched.
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end
          end
        end
        REQ: begin
          if (bus.mem_ready) begin
            r_mem_ce <= 1'b0;
            r_mem_we <= 1'b0;
            // Zero-wait memories may answer in the same cycle they accept.
            if (bus.mem_rvalid) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_resp_rdata <= w_capture;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= w_capture;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_req_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.mem_ce     = r_mem_ce;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_wmask  = r_mem_wmask;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Purpose : directed plus randomized bench for lsu_mem_master against an arithmetic reference model.
// Latency : checks 2-cycle best case, 1-cycle fault completion, and stretched handshakes.
// Backpres: drives random mem_ready / mem_rvalid / resp_ready delays.
module tb_lsu_mem_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  lsu_mem_master_if bus();

  lsu_mem_master dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: byte lanes covered by an access of 2**sz bytes at offset off.
  function automatic logic [7:0] ref_mask(int sz, int off);
    int m;
    m = ((1 << (1 << sz)) - 1) << off;
    return m[7:0];
  endfunction

  // Reference: pick 2**sz bytes starting at byte off, extend to 64 bits.
  function automatic logic [63:0] ref_load(logic [63:0] rdata, int sz, int off, bit uns);
    int          nb;
    logic [63:0] v;
    logic [63:0] keep;
    nb   = 1 << sz;
    v    = rdata >> (8 * off);
    keep = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    v    = v & keep;
    if (!uns && nb < 8 && v[8 * nb - 1]) v = v | ~keep;
    return v;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic wait_req_ready();
    int guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready_wait", {63'd0, bus.req_ready}, 64'd1);
  endtask

  task automatic run_txn(input bit we, input int sz, input bit uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata, input int rdy_dly,
                         input int rv_dly, input int rsp_dly);
    int          off;
    bit          al;
    logic [63:0] exp_rd;
    off    = int'(addr[2:0]);
    al     = (off % (1 << sz)) == 0;
    exp_rd = (!al || we) ? 64'd0 : ref_load(rdata, sz, off, uns);

    wait_req_ready();
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = 2'(sz);
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = rnd64();
    bus.req_wdata = rnd64();

    if (al) begin
      for (int k = 0; k <= rdy_dly; k++) begin
        chk("mem_ce", {63'd0, bus.mem_ce}, 64'd1);
        chk("mem_we", {63'd0, bus.mem_we}, {63'd0, we});
        chk("mem_addr", bus.mem_addr, {addr[63:3], 3'b000});
        chk("mem_wmask", {56'd0, bus.mem_wmask}, {56'd0, ref_mask(sz, off)});
        chk("mem_wdata", bus.mem_wdata, wdata << (8 * off));
        chk("req_ready_busy", {63'd0, bus.req_ready}, 64'd0);
        chk("resp_early", {63'd0, bus.resp_valid}, 64'd0);
        bus.mem_ready  = (k == rdy_dly);
        bus.mem_rvalid = (k == rdy_dly) && (rv_dly == 0);
        bus.mem_rdata  = bus.mem_rvalid ? rdata : rnd64();
        @(negedge clk);
      end
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      for (int k = 1; k <= rv_dly; k++) begin
        chk("mem_ce_wait", {63'd0, bus.mem_ce}, 64'd0);
        chk("resp_wait", {63'd0, bus.resp_valid}, 64'd0);
        bus.mem_rvalid = (k == rv_dly);
        bus.mem_rdata  = bus.mem_rvalid ? rdata : rnd64();
        @(negedge clk);
      end
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = rnd64();
    end

    for (int k = 0; k <= rsp_dly; k++) begin
      chk("resp_valid", {63'd0, bus.resp_valid}, 64'd1);
      chk("resp_rdata", bus.resp_rdata, exp_rd);
      chk("resp_err", {63'd0, bus.resp_err}, {63'd0, !al});
      chk("mem_ce_resp", {63'd0, bus.mem_ce}, 64'd0);
      chk("req_ready_resp", {63'd0, bus.req_ready}, 64'd0);
      bus.resp_ready = (k == rsp_dly);
      @(negedge clk);
    end
    bus.resp_ready = 1'b0;
    chk("resp_done", {63'd0, bus.resp_valid}, 64'd0);
    chk("req_ready_after", {63'd0, bus.req_ready}, 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.mem_ready    = 1'b0;
    bus.mem_rvalid   = 1'b0;
    bus.mem_rdata    = '0;
    bus.resp_ready   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("rst_mem_ce", {63'd0, bus.mem_ce}, 64'd0);
    chk("rst_mem_we", {63'd0, bus.mem_we}, 64'd0);
    chk("rst_mem_addr", bus.mem_addr, 64'd0);
    chk("rst_mem_wmask", {56'd0, bus.mem_wmask}, 64'd0);
    chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 64'd0);

    // Directed cases from the plan (expected data come from ref_load).
    run_txn(1'b0, 0, 1'b0, 64'h8000_0005, 64'd0, 64'h0000_8000_0000_0000, 0, 0, 0);
    run_txn(1'b1, 1, 1'b0, 64'h8000_0006, 64'h1234, 64'd0, 0, 0, 0);
    run_txn(1'b0, 2, 1'b1, 64'h8000_0004, 64'd0, 64'h8765_4321_0000_0000, 0, 0, 0);
    run_txn(1'b0, 2, 1'b0, 64'h8000_0002, 64'd0, 64'd0, 0, 0, 0);
    run_txn(1'b0, 3, 1'b0, 64'h8000_0010, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 3, 2, 2);

    // Abandon a load in WAIT via reset, then a stray response arrives in IDLE.
    wait_req_ready();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd3;
    bus.req_addr  = 64'h8000_0040;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    chk("abort_in_wait", {63'd0, bus.mem_ce}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("abort_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("abort_mem_addr", bus.mem_addr, 64'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rnd64();
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stray_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
      chk("stray_req_ready", {63'd0, bus.req_ready}, 64'd1);
      chk("stray_mem_ce", {63'd0, bus.mem_ce}, 64'd0);
      @(negedge clk);
    end
    run_txn(1'b0, 1, 1'b0, 64'h8000_0042, 64'd0, 64'h0000_0000_F00D_0000, 0, 1, 0);

    // Randomized traffic, mostly aligned with some faults mixed in.
    for (int t = 0; t < 200; t++) begin
      int          sz;
      logic [63:0] addr;
      sz   = $urandom_range(0, 3);
      addr = rnd64();
      if ($urandom_range(0, 4) != 0) addr = addr & ~((64'd1 << sz) - 64'd1);
      run_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, rnd64(), rnd64(),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
